// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor.
//   start/a/b/bin : request and operands (master -> slave)
//   busy/done     : operation status (slave -> master)
//   diff/bout     : result and final borrow (slave -> master)
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = serial_sub_pkg::DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);

endinterface

// File: rtl/fs_cell.sv
// One-bit full subtractor: d = x - y - bi, bo = borrow out.
//   x, y, bi : minuend bit, subtrahend bit, borrow in
//   d, bo    : difference bit, borrow out
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing diff = a - b - bin, LSB first, one bit per
// clock through a single full-subtractor cell.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of serial_subtractor_if (start/a/b/bin in,
//                busy/done/diff/bout out)
// A request accepted in IDLE is captured on that edge and SHIFT is entered on
// the following edge, so done appears WIDTH+1 edges after acceptance.
module serial_subtractor #(
  parameter int unsigned WIDTH = serial_sub_pkg::DEF_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  import serial_sub_pkg::*;

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic             armed_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             brw_q;
  logic [CW-1:0]    cnt_q;
  logic             step_d;
  logic             step_bo;
  logic             last_c;

  // Single arithmetic element; the result bits re-enter a_sr at the MSB.
  fs_cell u_fs (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (brw_q),
    .d  (step_d),
    .bo (step_bo)
  );

  assign last_c = (cnt_q == LAST_BIT);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (armed_q) state_d = SHIFT;
      SHIFT:   if (last_c)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and status flags, decoded from the next state so they
  // line up exactly with SHIFT and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state_q  <= state_d;
      bus.busy <= (state_d == SHIFT);
      bus.done <= (state_d == DONE);
    end
  end

  // Operand capture, serial datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q  <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // armed_q blocks a second capture in the cycle before SHIFT
          if (armed_q) begin
            armed_q <= 1'b0;
          end else if (bus.start) begin
            armed_q <= 1'b1;
            a_sr    <= bus.a;
            b_sr    <= bus.b;
            brw_q   <= bus.bin;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          a_sr  <= {step_d, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          brw_q <= step_bo;
          if (last_c) begin
            bus.diff <= {step_d, a_sr[WIDTH-1:1]};
            bus.bout <= step_bo;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_subtractor_if #(.WIDTH(8)) bus ();

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation: start accepted at the next edge, then start is re-asserted
  // through the arming cycle and early SHIFT (must be ignored) and operands
  // are scrambled (must not matter).
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tbin, input logic [7:0] ed, input logic eb);
    int lat;
    lat = 0;
    bus.a = ta; bus.b = tb; bus.bin = tbin; bus.start = 1'b1;
    step();
    bus.a = ~ta; bus.b = ~tb; bus.bin = ~tbin;
    while (bus.done !== 1'b1 && lat < 30) begin
      if (lat == 4) bus.start = 1'b0;
      step();
      lat++;
      chk({tag, "_overlap"}, 32'(bus.busy & bus.done), 32'd0);
    end
    bus.start = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'd9);
    chk({tag, "_diff"}, 32'(bus.diff), 32'(ed));
    chk({tag, "_bout"}, 32'(bus.bout), 32'(eb));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    step();
    chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_hold"}, 32'(bus.diff), 32'(ed));
    step();
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rbin;
    logic [8:0] m;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;

    // reset state
    step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // directed vectors
    run_op("op35_12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0);
    run_op("op00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run_op("op10_0F", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
    run_op("op00_FF", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);

    // start held high, operands change every cycle: a = k*17+5, b = k*3+1.
    // Accepted at k=0 (5-1=4) and k=11 (0xC0-0x22=0x9E); done at k=9 and k=20.
    bus.a = 8'd5; bus.b = 8'd1; bus.bin = 1'b0; bus.start = 1'b1;
    step();
    for (int k = 1; k <= 20; k++) begin
      bus.a = 8'(k * 17 + 5);
      bus.b = 8'(k * 3 + 1);
      step();
      chk("hold_overlap", 32'(bus.busy & bus.done), 32'd0);
      if (k == 9) begin
        chk("hold1_done", 32'(bus.done), 32'd1);
        chk("hold1_diff", 32'(bus.diff), 32'h04);
        chk("hold1_bout", 32'(bus.bout), 32'd0);
      end else if (k == 20) begin
        chk("hold2_done", 32'(bus.done), 32'd1);
        chk("hold2_diff", 32'(bus.diff), 32'h9E);
        chk("hold2_bout", 32'(bus.bout), 32'd0);
      end else begin
        chk("hold_nodone", 32'(bus.done), 32'd0);
      end
      if (k == 10) chk("hold_idle_gap", 32'(bus.busy), 32'd0);
    end
    bus.start = 1'b0;
    step();
    step();
    chk("hold_stopped", 32'(bus.busy), 32'd0);

    // reset during SHIFT cycle 4
    bus.a = 8'h77; bus.b = 8'h11; bus.bin = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("mid_busy_pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_diff", 32'(bus.diff), 32'd0);
    chk("mid_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("mid_nodone", 32'(bus.done), 32'd0);
    end
    run_op("after_rst", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // random sweep against 9-bit reference subtraction
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rbin = 1'($urandom);
      m = {1'b0, ra} - {1'b0, rb} - 9'(rbin);
      run_op("rand", ra, rb, rbin, m[7:0], m[8]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
